// File: rtl/load_store_unit.sv
// load_store_unit: bridges the core memory stage to a word-wide data memory.
// One request at a time; byte/half stores become read-modify-write, loads are
// extended per RV32I funct3, and misaligned/illegal accesses never touch memory.
module load_store_unit #(
    parameter int A_BITS = 10,
    parameter int D_BITS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [A_BITS+1:0] req_addr,
    input  logic [D_BITS-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [D_BITS-1:0] rsp_rdata,
    output logic              rsp_misaligned,
    output logic [A_BITS-1:0] mem_address,
    output logic [D_BITS-1:0] mem_data_in,
    output logic              mem_read_en,
    output logic              mem_write_en,
    input  logic [D_BITS-1:0] mem_data_out
);

    typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, RESP} state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    // Misaligned halfword/word access or a funct3 with no RV32I encoding.
    function automatic logic access_error(input logic we, input logic [2:0] f3,
                                          input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        if (we && f3 > 3'd2)
            bad = 1'b1;
        if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7))
            bad = 1'b1;
        if (f3[1:0] == 2'd1 && lo[0])
            bad = 1'b1;
        if (f3[1:0] == 2'd2 && lo != 2'd0)
            bad = 1'b1;
        return bad;
    endfunction

    // Pick the addressed byte/half out of the word and sign- or zero-extend it.
    function automatic logic [D_BITS-1:0] load_extend(input logic [2:0] f3,
                                                      input logic [1:0] lane,
                                                      input logic [D_BITS-1:0] word);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [D_BITS-1:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd4:    r = {24'd0, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd5:    r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte (SB) or half (SH) of the fetched word.
    function automatic logic [D_BITS-1:0] store_merge(input logic [2:0] f3,
                                                      input logic [1:0] lane,
                                                      input logic [D_BITS-1:0] word,
                                                      input logic [15:0] wd);
        logic [D_BITS-1:0] r;
        r = word;
        case (f3)
            3'd0:    r[{lane, 3'b000} +: 8] = wd[7:0];
            3'd1:    r[{lane[1], 4'b0000} +: 16] = wd;
            default: r = word;
        endcase
        return r;
    endfunction

    // Request FSM with all memory-side and response outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            funct3_q       <= 3'd0;
            lane_q         <= 2'd0;
            wdata_q        <= 16'd0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_misaligned <= 1'b0;
            mem_address    <= '0;
            mem_data_in    <= '0;
            mem_read_en    <= 1'b0;
            mem_write_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q    <= req_funct3;
                        lane_q      <= req_addr[1:0];
                        wdata_q     <= req_wdata[15:0];
                        mem_address <= req_addr[A_BITS+1:2];
                        req_ready   <= 1'b0;
                        if (access_error(req_we, req_funct3, req_addr[1:0])) begin
                            state          <= RESP;
                            rsp_valid      <= 1'b1;
                            rsp_misaligned <= 1'b1;
                            rsp_rdata      <= '0;
                        end else if (!req_we) begin
                            state       <= LOAD;
                            mem_read_en <= 1'b1;
                        end else if (req_funct3 == 3'd2) begin
                            state        <= WRITE;
                            mem_write_en <= 1'b1;
                            mem_data_in  <= req_wdata;
                        end else begin
                            state       <= READ;
                            mem_read_en <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state       <= RESP;
                    mem_read_en <= 1'b0;
                    rsp_valid   <= 1'b1;
                    rsp_rdata   <= load_extend(funct3_q, lane_q, mem_data_out);
                end
                READ: begin
                    state        <= WRITE;
                    mem_read_en  <= 1'b0;
                    mem_write_en <= 1'b1;
                    mem_data_in  <= store_merge(funct3_q, lane_q, mem_data_out, wdata_q);
                end
                WRITE: begin
                    state        <= RESP;
                    mem_write_en <= 1'b0;
                    mem_data_in  <= '0;
                    rsp_valid    <= 1'b1;
                    rsp_rdata    <= '0;
                end
                RESP: begin
                    state          <= IDLE;
                    rsp_valid      <= 1'b0;
                    rsp_rdata      <= '0;
                    rsp_misaligned <= 1'b0;
                    mem_address    <= '0;
                    req_ready      <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic [9:0]  mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_data_out;

    logic [31:0] mem [0:1023];
    logic        mem_clear;
    logic        mon_en;
    int          cyc;
    int          vectors;
    int          miscompares;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          nrd;
        int          nwr;
        logic [9:0]  waddr;
        logic [31:0] wd;
        int          acc;
    } exp_t;

    exp_t sb_q[$];

    load_store_unit #(.A_BITS(10), .D_BITS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misaligned(rsp_misaligned),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_data_out(mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, synchronous write.
    assign mem_data_out = mem[mem_address];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h11223344;
        end else if (mem_write_en) begin
            mem[mem_address] <= mem_data_in;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic [31:0] ex_rd, input logic ex_mis,
                         input int lat, input int nrd, input int nwr, input logic [31:0] ex_wd,
                         input logic hold);
        exp_t e;
        int n;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.rdata = ex_rd;
        e.mis   = ex_mis;
        e.lat   = lat;
        e.nrd   = nrd;
        e.nwr   = nwr;
        e.waddr = addr[11:2];
        e.wd    = ex_wd;
        e.acc   = cyc + 1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    // Monitor: per-transaction enable accounting and response comparison.
    int  rd_cnt;
    int  wr_cnt;
    logic rdy_next;
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb_q.size() > 0 && cyc >= sb_q[0].acc) begin
                check("ready_low_busy", 32'(req_ready), 32'd0);
                if (mem_read_en || mem_write_en) begin
                    check("rd_wr_exclusive", 32'(mem_read_en && mem_write_en), 32'd0);
                    check("mem_address", 32'(mem_address), 32'(sb_q[0].waddr));
                end
                if (mem_read_en) rd_cnt++;
                if (mem_write_en) begin
                    wr_cnt++;
                    check("mem_data_in", mem_data_in, sb_q[0].wd);
                end
                if (rsp_valid) begin
                    check("rsp_rdata", rsp_rdata, sb_q[0].rdata);
                    check("rsp_misaligned", 32'(rsp_misaligned), 32'(sb_q[0].mis));
                    check("latency", 32'(cyc - sb_q[0].acc), 32'(sb_q[0].lat));
                    check("read_pulses", 32'(rd_cnt), 32'(sb_q[0].nrd));
                    check("write_pulses", 32'(wr_cnt), 32'(sb_q[0].nwr));
                    void'(sb_q.pop_front());
                    rd_cnt = 0;
                    wr_cnt = 0;
                    rdy_next = 1'b1;
                end
            end else begin
                check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
                check("idle_enables", {30'd0, mem_read_en, mem_write_en}, 32'd0);
                if (rdy_next) begin
                    check("ready_after_resp", 32'(req_ready), 32'd1);
                    rdy_next = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        cyc = 0;
        vectors = 0;
        miscompares = 0;
        rd_cnt = 0;
        wr_cnt = 0;
        rdy_next = 1'b0;
        mon_en = 1'b0;
        mem_clear = 1'b1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 12'd0;
        req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_outputs", {28'd0, rsp_valid, rsp_misaligned, mem_read_en, mem_write_en}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_address", 32'(mem_address), 32'd0);
        check("reset_data_in", mem_data_in, 32'd0);
        mem_clear = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset during the WRITE of an SB must suppress the write and the response.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0;
        req_addr = 12'h011; req_wdata = 32'h000000A5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rst_sb_read_en", 32'(mem_read_en), 32'd1);
        @(posedge clk);
        #1;
        check("rst_sb_write_en", 32'(mem_write_en), 32'd1);
        check("rst_sb_merge", mem_data_in, 32'h1122A544);
        rst_n = 1'b0;
        #1;
        check("rst_write_en_drop", 32'(mem_write_en), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_address", 32'(mem_address), 32'd0);
        @(posedge clk);
        #1;
        check("rst_mem_unchanged", mem[4], 32'h11223344);
        check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready_release", 32'(req_ready), 32'd1);
        mon_en = 1'b1;

        // we f3 addr wdata | rdata mis lat nrd nwr wd hold
        issue(1, 3'd2, 12'h010, 32'hDEADBEEF, 32'h0,        0, 1, 0, 1, 32'hDEADBEEF, 0);
        issue(0, 3'd2, 12'h010, 32'h0,        32'hDEADBEEF, 0, 1, 1, 0, 32'h0,        0);
        issue(1, 3'd0, 12'h011, 32'h000000A5, 32'h0,        0, 2, 1, 1, 32'hDEADA5EF, 0);
        issue(0, 3'd0, 12'h011, 32'h0,        32'hFFFFFFA5, 0, 1, 1, 0, 32'h0,        0);
        issue(0, 3'd4, 12'h011, 32'h0,        32'h000000A5, 0, 1, 1, 0, 32'h0,        0);
        issue(1, 3'd1, 12'h012, 32'h00008001, 32'h0,        0, 2, 1, 1, 32'h8001A5EF, 0);
        issue(0, 3'd1, 12'h012, 32'h0,        32'hFFFF8001, 0, 1, 1, 0, 32'h0,        0);
        issue(0, 3'd5, 12'h012, 32'h0,        32'h00008001, 0, 1, 1, 0, 32'h0,        0);
        issue(0, 3'd1, 12'h010, 32'h0,        32'hFFFFA5EF, 0, 1, 1, 0, 32'h0,        0);
        issue(0, 3'd2, 12'h013, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,        0);
        issue(1, 3'd1, 12'h011, 32'h0000FFFF, 32'h0,        1, 0, 0, 0, 32'h0,        0);
        issue(0, 3'd3, 12'h010, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,        0);
        issue(1, 3'd4, 12'h010, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,        0);
        issue(0, 3'd2, 12'h010, 32'h0,        32'h8001A5EF, 0, 1, 1, 0, 32'h0,        0);

        // Back-to-back with req_valid held high.
        issue(1, 3'd2, 12'h020, 32'h12345678, 32'h0,        0, 1, 0, 1, 32'h12345678, 1);
        issue(1, 3'd0, 12'h021, 32'h0000009C, 32'h0,        0, 2, 1, 1, 32'h12349C78, 1);
        issue(0, 3'd2, 12'h020, 32'h0,        32'h12349C78, 0, 1, 1, 0, 32'h0,        1);
        issue(0, 3'd0, 12'h023, 32'h0,        32'h00000012, 0, 1, 1, 0, 32'h0,        0);

        n = 0;
        while (sb_q.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", 32'(sb_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
